// File: rtl/general_register_freelist.sv
// Free list for the 64 physical general registers.
// Grants up to two release requests per cycle (lowest index first), queues the
// granted names in a 64-deep circular FIFO, and presents the two oldest names
// to rename.
// Ports:
//   iCLOCK, inRESET                 clock, async active-low reset
//   iFREE_RESTART                   rollback flush; masks grants, pops and valids
//   iENTRY_FREELIST_REQ[63:0]       per-entry release requests
//   oENTRY_FREELIST_REGIST_VALID    combinational acknowledge (one/two-hot)
//   iALLOC_0_REQ / iALLOC_1_REQ     rename consumes head / head+1
//   oFREE_0_* / oFREE_1_*           head and head+1 valid + name
//   oFREE_COUNT[6:0]                number of queued names
module general_register_freelist (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFREE_RESTART,
  input  logic [63:0] iENTRY_FREELIST_REQ,
  output logic [63:0] oENTRY_FREELIST_REGIST_VALID,
  input  logic        iALLOC_0_REQ,
  input  logic        iALLOC_1_REQ,
  output logic        oFREE_0_VALID,
  output logic [5:0]  oFREE_0_REGNAME,
  output logic        oFREE_1_VALID,
  output logic [5:0]  oFREE_1_REGNAME,
  output logic [6:0]  oFREE_COUNT
);

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
  localparam int unsigned CW    = 7;

  logic [AW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          g0_found, g1_found;
  logic [AW-1:0] g0_idx, g1_idx;
  logic [63:0]   req_rem;
  logic [CW-1:0] avail;
  logic          grant0, grant1;
  logic          pop0, pop1;
  logic [CW-1:0] n_push, n_pop;

  // Lowest and next-lowest requesting entries.
  always_comb begin
    g0_found = 1'b0;
    g0_idx   = '0;
    g1_found = 1'b0;
    g1_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (iENTRY_FREELIST_REQ[i]) begin
        g0_found = 1'b1;
        g0_idx   = AW'(i);
      end
    end
    req_rem = iENTRY_FREELIST_REQ;
    if (g0_found) req_rem[g0_idx] = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req_rem[i]) begin
        g1_found = 1'b1;
        g1_idx   = AW'(i);
      end
    end
  end

  // Grant against space left at the start of the cycle; same-cycle pops do
  // not create room until the next cycle.
  always_comb begin
    avail  = CW'(DEPTH) - count_q;
    grant0 = g0_found && (avail >= CW'(1)) && !iFREE_RESTART;
    grant1 = g1_found && (avail >= CW'(2)) && !iFREE_RESTART;
    oENTRY_FREELIST_REGIST_VALID = '0;
    if (grant0) oENTRY_FREELIST_REGIST_VALID[g0_idx] = 1'b1;
    if (grant1) oENTRY_FREELIST_REGIST_VALID[g1_idx] = 1'b1;
  end

  // Head outputs; a second pop is only honoured alongside the first.
  always_comb begin
    oFREE_0_VALID   = (count_q >= CW'(1)) && !iFREE_RESTART;
    oFREE_1_VALID   = (count_q >= CW'(2)) && !iFREE_RESTART;
    oFREE_0_REGNAME = mem_q[rptr_q];
    oFREE_1_REGNAME = mem_q[rptr_q + AW'(1)];
    oFREE_COUNT     = count_q;
    pop0            = iALLOC_0_REQ && oFREE_0_VALID;
    pop1            = iALLOC_0_REQ && iALLOC_1_REQ && oFREE_1_VALID;
  end

  // Pointer and count next state.
  always_comb begin
    n_push  = CW'(grant0) + CW'(grant1);
    n_pop   = CW'(pop0) + CW'(pop1);
    wptr_d  = wptr_q + AW'(n_push);
    rptr_d  = rptr_q + AW'(n_pop);
    count_d = count_q + n_push - n_pop;
    if (iFREE_RESTART) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Name memory; reset keeps REGNAME outputs defined while empty.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (grant0) mem_q[wptr_q]          <= g0_idx;
      if (grant1) mem_q[wptr_q + AW'(1)] <= g1_idx;
    end
  end

endmodule

// File: tb/tb_general_register_freelist.sv
module tb_general_register_freelist;

  logic        iCLOCK;
  logic        inRESET;
  logic        iFREE_RESTART;
  logic [63:0] iENTRY_FREELIST_REQ;
  logic [63:0] oENTRY_FREELIST_REGIST_VALID;
  logic        iALLOC_0_REQ;
  logic        iALLOC_1_REQ;
  logic        oFREE_0_VALID;
  logic [5:0]  oFREE_0_REGNAME;
  logic        oFREE_1_VALID;
  logic [5:0]  oFREE_1_REGNAME;
  logic [6:0]  oFREE_COUNT;

  int n_checks = 0;
  int n_fail   = 0;

  general_register_freelist dut (
    .iCLOCK                       (iCLOCK),
    .inRESET                      (inRESET),
    .iFREE_RESTART                (iFREE_RESTART),
    .iENTRY_FREELIST_REQ          (iENTRY_FREELIST_REQ),
    .oENTRY_FREELIST_REGIST_VALID (oENTRY_FREELIST_REGIST_VALID),
    .iALLOC_0_REQ                 (iALLOC_0_REQ),
    .iALLOC_1_REQ                 (iALLOC_1_REQ),
    .oFREE_0_VALID                (oFREE_0_VALID),
    .oFREE_0_REGNAME              (oFREE_0_REGNAME),
    .oFREE_1_VALID                (oFREE_1_VALID),
    .oFREE_1_REGNAME              (oFREE_1_REGNAME),
    .oFREE_COUNT                  (oFREE_COUNT)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  task automatic tick;
    @(posedge iCLOCK);
    #1;
  endtask

  // Drive a request set, dropping bits after their acknowledge; the two lowest
  // pending bits are expected each cycle (callers guarantee free space).
  task automatic fill(input logic [63:0] v, input int exp_cycles, input string tag);
    logic [63:0] pending, exp_ack;
    int cyc, found;
    pending = v;
    cyc = 0;
    iENTRY_FREELIST_REQ = pending;
    #1;
    while (pending != '0 && cyc < 70) begin
      exp_ack = '0;
      found = 0;
      for (int i = 0; i < 64; i++) begin
        if (pending[i] && found < 2) begin
          exp_ack[i] = 1'b1;
          found++;
        end
      end
      n_checks++;
      if (oENTRY_FREELIST_REGIST_VALID !== exp_ack) begin
        n_fail++;
        $display("FAIL %s_ack cyc%0d: got %h expected %h", tag, cyc, oENTRY_FREELIST_REGIST_VALID, exp_ack);
      end
      tick;
      pending = pending & ~exp_ack;
      iENTRY_FREELIST_REQ = pending;
      cyc++;
      #1;
    end
    n_checks++;
    if (cyc !== exp_cycles) begin
      n_fail++;
      $display("FAIL %s_cycles: got %0d expected %0d", tag, cyc, exp_cycles);
    end
  endtask

  task automatic do_restart;
    iFREE_RESTART = 1'b1;
    tick;
    iFREE_RESTART = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    n_checks++;
    if (oFREE_COUNT !== 7'd0 || oFREE_0_VALID !== 1'b0 || oFREE_1_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: count %0d v0 %b v1 %b expected 0 0 0", oFREE_COUNT, oFREE_0_VALID, oFREE_1_VALID);
    end
    n_checks++;
    if (oFREE_0_REGNAME !== 6'd0 || oFREE_1_REGNAME !== 6'd0 || oENTRY_FREELIST_REGIST_VALID !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_names: n0 %0d n1 %0d ack %h expected 0 0 0", oFREE_0_REGNAME, oFREE_1_REGNAME, oENTRY_FREELIST_REGIST_VALID);
    end
  endtask

  task automatic test_fill;
    fill(64'hFFFF_FFFF_0000_0000, 16, "fill");
    n_checks++;
    if (oFREE_COUNT !== 7'd32 || oFREE_0_REGNAME !== 6'd32 || oFREE_1_REGNAME !== 6'd33) begin
      n_fail++;
      $display("FAIL fill_end: count %0d n0 %0d n1 %0d expected 32 32 33", oFREE_COUNT, oFREE_0_REGNAME, oFREE_1_REGNAME);
    end
  endtask

  task automatic test_dual_pop;
    iALLOC_0_REQ = 1'b1;
    iALLOC_1_REQ = 1'b1;
    tick;
    iALLOC_0_REQ = 1'b0;
    iALLOC_1_REQ = 1'b0;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd30 || oFREE_0_REGNAME !== 6'd34 || oFREE_1_REGNAME !== 6'd35) begin
      n_fail++;
      $display("FAIL dual_pop: count %0d n0 %0d n1 %0d expected 30 34 35", oFREE_COUNT, oFREE_0_REGNAME, oFREE_1_REGNAME);
    end
    iALLOC_1_REQ = 1'b1;
    tick;
    iALLOC_1_REQ = 1'b0;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd30 || oFREE_0_REGNAME !== 6'd34) begin
      n_fail++;
      $display("FAIL alloc1_alone: count %0d n0 %0d expected 30 34", oFREE_COUNT, oFREE_0_REGNAME);
    end
  endtask

  task automatic test_push_pop;
    do_restart;
    fill(64'h0000_0000_0000_0020, 1, "pp_seed");
    n_checks++;
    if (oFREE_COUNT !== 7'd1 || oFREE_0_REGNAME !== 6'd5 || oFREE_1_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_seed_state: count %0d n0 %0d v1 %b expected 1 5 0", oFREE_COUNT, oFREE_0_REGNAME, oFREE_1_VALID);
    end
    iENTRY_FREELIST_REQ = 64'h0000_0000_0000_0200;
    iALLOC_0_REQ = 1'b1;
    #1;
    n_checks++;
    if (oENTRY_FREELIST_REGIST_VALID !== 64'h0000_0000_0000_0200) begin
      n_fail++;
      $display("FAIL pp_ack: got %h expected %h", oENTRY_FREELIST_REGIST_VALID, 64'h200);
    end
    tick;
    iENTRY_FREELIST_REQ = '0;
    iALLOC_0_REQ = 1'b0;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd1 || oFREE_0_REGNAME !== 6'd9 || oFREE_0_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL push_pop: count %0d n0 %0d v0 %b expected 1 9 1", oFREE_COUNT, oFREE_0_REGNAME, oFREE_0_VALID);
    end
  endtask

  task automatic test_near_full;
    do_restart;
    fill(64'h7FFF_FFFF_FFFF_FFFF, 32, "nf_fill");
    n_checks++;
    if (oFREE_COUNT !== 7'd63) begin
      n_fail++;
      $display("FAIL nf_count63: got %0d expected 63", oFREE_COUNT);
    end
    iENTRY_FREELIST_REQ = 64'h0000_0000_0000_1080;
    #1;
    n_checks++;
    if (oENTRY_FREELIST_REGIST_VALID !== 64'h0000_0000_0000_0080) begin
      n_fail++;
      $display("FAIL nf_ack63: got %h expected %h", oENTRY_FREELIST_REGIST_VALID, 64'h80);
    end
    tick;
    iENTRY_FREELIST_REQ = 64'h0000_0000_0000_1000;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd64 || oENTRY_FREELIST_REGIST_VALID !== 64'd0 || oFREE_1_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL nf_full: count %0d ack %h v1 %b expected 64 0 1", oFREE_COUNT, oENTRY_FREELIST_REGIST_VALID, oFREE_1_VALID);
    end
    tick;
    iENTRY_FREELIST_REQ = '0;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd64) begin
      n_fail++;
      $display("FAIL nf_hold: got %0d expected 64", oFREE_COUNT);
    end
  endtask

  task automatic test_wrap;
    do_restart;
    fill(64'h7FFF_FFFF_FFFF_FFFF, 32, "wr_fill");
    iALLOC_0_REQ = 1'b1;
    iALLOC_1_REQ = 1'b1;
    tick;
    iALLOC_0_REQ = 1'b0;
    iALLOC_1_REQ = 1'b0;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd61 || oFREE_0_REGNAME !== 6'd2) begin
      n_fail++;
      $display("FAIL wr_pop2: count %0d n0 %0d expected 61 2", oFREE_COUNT, oFREE_0_REGNAME);
    end
    // wptr is 63: names 40 and 41 straddle the wrap.
    fill(64'h0000_0300_0000_0000, 1, "wr_push");
    n_checks++;
    if (oFREE_COUNT !== 7'd63) begin
      n_fail++;
      $display("FAIL wr_push_count: got %0d expected 63", oFREE_COUNT);
    end
    for (int k = 0; k < 30; k++) begin
      iALLOC_0_REQ = 1'b1;
      iALLOC_1_REQ = 1'b1;
      tick;
    end
    iALLOC_0_REQ = 1'b0;
    iALLOC_1_REQ = 1'b0;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd3 || oFREE_0_REGNAME !== 6'd62 || oFREE_1_REGNAME !== 6'd40) begin
      n_fail++;
      $display("FAIL wr_at62: count %0d n0 %0d n1 %0d expected 3 62 40", oFREE_COUNT, oFREE_0_REGNAME, oFREE_1_REGNAME);
    end
    iALLOC_0_REQ = 1'b1;
    tick;
    iALLOC_0_REQ = 1'b0;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd2 || oFREE_0_REGNAME !== 6'd40 || oFREE_1_REGNAME !== 6'd41) begin
      n_fail++;
      $display("FAIL wr_straddle: count %0d n0 %0d n1 %0d expected 2 40 41", oFREE_COUNT, oFREE_0_REGNAME, oFREE_1_REGNAME);
    end
    iALLOC_0_REQ = 1'b1;
    iALLOC_1_REQ = 1'b1;
    tick;
    iALLOC_0_REQ = 1'b0;
    iALLOC_1_REQ = 1'b0;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd0 || oFREE_0_VALID !== 1'b0 || oFREE_1_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_empty: count %0d v0 %b v1 %b expected 0 0 0", oFREE_COUNT, oFREE_0_VALID, oFREE_1_VALID);
    end
    iALLOC_0_REQ = 1'b1;
    tick;
    iALLOC_0_REQ = 1'b0;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd0) begin
      n_fail++;
      $display("FAIL empty_alloc: count %0d expected 0", oFREE_COUNT);
    end
  endtask

  task automatic test_restart;
    fill(64'h0000_0000_000F_FFFF, 10, "rs_fill");
    n_checks++;
    if (oFREE_COUNT !== 7'd20) begin
      n_fail++;
      $display("FAIL rs_count20: got %0d expected 20", oFREE_COUNT);
    end
    iFREE_RESTART = 1'b1;
    iENTRY_FREELIST_REQ = 64'h0000_0000_C000_0000;
    iALLOC_0_REQ = 1'b1;
    #1;
    n_checks++;
    if (oENTRY_FREELIST_REGIST_VALID !== 64'd0 || oFREE_0_VALID !== 1'b0 || oFREE_1_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL rs_pulse: ack %h v0 %b v1 %b expected 0 0 0", oENTRY_FREELIST_REGIST_VALID, oFREE_0_VALID, oFREE_1_VALID);
    end
    tick;
    iFREE_RESTART = 1'b0;
    iALLOC_0_REQ = 1'b0;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd0 || oENTRY_FREELIST_REGIST_VALID !== 64'h0000_0000_C000_0000) begin
      n_fail++;
      $display("FAIL rs_after: count %0d ack %h expected 0 c0000000", oFREE_COUNT, oENTRY_FREELIST_REGIST_VALID);
    end
    tick;
    iENTRY_FREELIST_REQ = '0;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd2 || oFREE_0_REGNAME !== 6'd30 || oFREE_1_REGNAME !== 6'd31) begin
      n_fail++;
      $display("FAIL rs_new: count %0d n0 %0d n1 %0d expected 2 30 31", oFREE_COUNT, oFREE_0_REGNAME, oFREE_1_REGNAME);
    end
  endtask

  task automatic test_async_reset;
    #2;
    inRESET = 1'b0;
    #1;
    n_checks++;
    if (oFREE_COUNT !== 7'd0 || oFREE_0_VALID !== 1'b0 || oFREE_0_REGNAME !== 6'd0) begin
      n_fail++;
      $display("FAIL async_reset: count %0d v0 %b n0 %0d expected 0 0 0", oFREE_COUNT, oFREE_0_VALID, oFREE_0_REGNAME);
    end
    #1;
    inRESET = 1'b1;
    tick;
  endtask

  initial begin
    inRESET = 1'b0;
    iFREE_RESTART = 1'b0;
    iENTRY_FREELIST_REQ = '0;
    iALLOC_0_REQ = 1'b0;
    iALLOC_1_REQ = 1'b0;
    #12;
    test_reset;
    inRESET = 1'b1;
    tick;
    test_fill;
    test_dual_pop;
    test_push_pop;
    test_near_full;
    test_wrap;
    test_restart;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
